// File: rtl/az_pwm_sequencer.sv
// ---------------------------------------------------------------------------
// az_pwm_sequencer
//
// Generates the periodic autozero pulse for the end-of-column logic from the
// 27-bit AZ shadow word. The waveform is an optional one-shot delay followed
// by a repeating HIGH/LOW pattern. Timing fields are copied into active
// registers only at load points: a start, a SYNC, or a LOW-to-HIGH wrap.
// This means a JTAG update that lands mid-period cannot clip or stretch the
// pulse that is currently being generated.
//
// Ports
//   CLK          system clock (40 MHz); every count is in CLK cycles
//   RESET        asynchronous, active-low reset
//   ENABLE       run enable, level-sensitive
//   SYNC         single-cycle restart strobe, ignored while ENABLE=0
//   CONFIG[26:0] [4:0]=Ndelay, [12:5]=Nhigh, [26:13]=Nlow
//   AZ_PULSE     registered autozero pulse, high while in HIGH
//   PHASE[1:0]   00=IDLE 01=DELAY 10=HIGH 11=LOW
//   PERIOD_DONE  high during the final LOW cycle of each period
//   PULSE_CNT    completed HIGH phases, wraps modulo 256
// ---------------------------------------------------------------------------
module az_pwm_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        SYNC,
    input  logic [26:0] CONFIG,
    output logic        AZ_PULSE,
    output logic [1:0]  PHASE,
    output logic        PERIOD_DONE,
    output logic [7:0]  PULSE_CNT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DELAY = 2'b01,
        S_HIGH  = 2'b10,
        S_LOW   = 2'b11
    } state_t;

    // Raw fields of the incoming shadow word
    logic [4:0]  cfg_ndelay;
    logic [7:0]  cfg_nhigh;
    logic [13:0] cfg_nlow;

    assign cfg_ndelay = CONFIG[4:0];
    assign cfg_nhigh  = CONFIG[12:5];
    assign cfg_nlow   = CONFIG[26:13];

    state_t      state_q, state_d;
    logic [13:0] cnt_q, cnt_d;
    logic [7:0]  nhigh_q, nhigh_d;
    logic [13:0] nlow_q, nlow_d;
    logic        az_q, az_d;
    logic        pd_q, pd_d;
    logic [7:0]  pcnt_q, pcnt_d;

    // LOW always lasts at least one cycle so a period is never zero-length.
    function automatic logic [13:0] low_load(input logic [13:0] nlow);
        return (nlow == 14'd0) ? 14'd0 : (nlow - 14'd1);
    endfunction

    // Counter value for the first cycle of HIGH.
    function automatic logic [13:0] high_load(input logic [7:0] nhigh);
        return {6'd0, nhigh} - 14'd1;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    //
    // The delay field is consumed only at the instant it would be
    // latched (start / SYNC), where it goes straight into the counter, so
    // no separate active copy of Ndelay is kept.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nhigh_d = nhigh_q;
        nlow_d  = nlow_q;
        pcnt_d  = pcnt_q;

        if (!ENABLE) begin
            // Disable overrides everything; an in-flight pulse is
            // dropped without being counted.
            state_d = S_IDLE;
            cnt_d   = 14'd0;
        end else if (SYNC || (state_q == S_IDLE)) begin
            // Start or restart: take the whole word, then skip DELAY
            // and/or HIGH when their counts are zero.
            nhigh_d = cfg_nhigh;
            nlow_d  = cfg_nlow;
            if (cfg_ndelay != 5'd0) begin
                state_d = S_DELAY;
                cnt_d   = {9'd0, cfg_ndelay} - 14'd1;
            end else if (cfg_nhigh != 8'd0) begin
                state_d = S_HIGH;
                cnt_d   = high_load(cfg_nhigh);
            end else begin
                state_d = S_LOW;
                cnt_d   = low_load(cfg_nlow);
            end
        end else begin
            case (state_q)
                S_DELAY: begin
                    if (cnt_q == 14'd0) begin
                        if (nhigh_q != 8'd0) begin
                            state_d = S_HIGH;
                            cnt_d   = high_load(nhigh_q);
                        end else begin
                            state_d = S_LOW;
                            cnt_d   = low_load(nlow_q);
                        end
                    end else begin
                        cnt_d = cnt_q - 14'd1;
                    end
                end
                S_HIGH: begin
                    if (cnt_q == 14'd0) begin
                        state_d = S_LOW;
                        cnt_d   = low_load(nlow_q);
                        pcnt_d  = pcnt_q + 8'd1;
                    end else begin
                        cnt_d = cnt_q - 14'd1;
                    end
                end
                S_LOW: begin
                    if (cnt_q == 14'd0) begin
                        // Period boundary: pick up new high/low widths.
                        nhigh_d = cfg_nhigh;
                        nlow_d  = cfg_nlow;
                        if (cfg_nhigh != 8'd0) begin
                            state_d = S_HIGH;
                            cnt_d   = high_load(cfg_nhigh);
                        end else begin
                            state_d = S_LOW;
                            cnt_d   = low_load(cfg_nlow);
                        end
                    end else begin
                        cnt_d = cnt_q - 14'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 14'd0;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up
        // exactly with the phase they describe.
        az_d = (state_d == S_HIGH);
        pd_d = (state_d == S_LOW) && (cnt_d == 14'd0);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 14'd0;
            nhigh_q <= 8'd0;
            nlow_q  <= 14'd0;
            az_q    <= 1'b0;
            pd_q    <= 1'b0;
            pcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nhigh_q <= nhigh_d;
            nlow_q  <= nlow_d;
            az_q    <= az_d;
            pd_q    <= pd_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign AZ_PULSE    = az_q;
    assign PHASE       = state_q;
    assign PERIOD_DONE = pd_q;
    assign PULSE_CNT   = pcnt_q;

endmodule

// File: tb/tb_az_pwm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_az_pwm_sequencer
//
// Directed bench for az_pwm_sequencer. Each scenario pushes hand-computed
// pulse records (rise cycle, width) and PERIOD_DONE cycles into queues; a
// monitor pops and compares whenever the DUT shows a pulse end or a
// PERIOD_DONE. Point checks on PHASE / PULSE_CNT cover the rest.
// Cycle numbering: cyc counts posedges; outputs are sampled on negedge.
// ---------------------------------------------------------------------------
module tb_az_pwm_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        ENABLE = 1'b0;
    logic        SYNC = 1'b0;
    logic [26:0] CONFIG = 27'd0;
    logic        AZ_PULSE;
    logic [1:0]  PHASE;
    logic        PERIOD_DONE;
    logic [7:0]  PULSE_CNT;

    az_pwm_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .SYNC        (SYNC),
        .CONFIG      (CONFIG),
        .AZ_PULSE    (AZ_PULSE),
        .PHASE       (PHASE),
        .PERIOD_DONE (PERIOD_DONE),
        .PULSE_CNT   (PULSE_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    typedef struct {
        int rise;
        int width;
    } pulse_t;

    pulse_t pulse_q[$];
    int     pd_q[$];
    int     tests = 0;
    int     fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [26:0] cfg(input logic [4:0] nd, input logic [7:0] nh,
                                        input logic [13:0] nl);
        return {nl, nh, nd};
    endfunction

    task automatic push_pulse(input int rise, input int width);
        pulse_t p;
        p.rise  = rise;
        p.width = width;
        pulse_q.push_back(p);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge CLK);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_az"},    int'(AZ_PULSE),    0);
        check({tag, "_phase"}, int'(PHASE),       0);
        check({tag, "_pd"},    int'(PERIOD_DONE), 0);
        check({tag, "_pcnt"},  int'(PULSE_CNT),   0);
    endtask

    task automatic do_reset();
        RESET  = 1'b0;
        ENABLE = 1'b0;
        SYNC   = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    // ---------------- monitor ----------------
    logic   az_prev = 1'b0;
    int     rise_c  = 0;
    pulse_t mon_p;

    always @(negedge CLK) begin
        if (PERIOD_DONE) begin
            if (pd_q.size() == 0) check("pd_unexpected", cyc, -1);
            else                  check("pd_cycle", cyc, pd_q.pop_front());
        end
        if (AZ_PULSE && !az_prev) rise_c = cyc;
        if (!AZ_PULSE && az_prev) begin
            if (pulse_q.size() == 0) begin
                check("pulse_unexpected", rise_c, -1);
            end else begin
                mon_p = pulse_q.pop_front();
                check("pulse_rise", rise_c, mon_p.rise);
                check("pulse_width", cyc - rise_c, mon_p.width);
            end
        end
        az_prev = AZ_PULSE;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0;

        repeat (2) @(negedge CLK);
        check_reset_vals("reset");
        RESET = 1'b1;
        @(negedge CLK);

        // Default word: 20 high / 3980 low, three periods
        CONFIG = cfg(5'd0, 8'd20, 14'd3980);
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            push_pulse(c0 + 1 + 4000 * k, 20);
            pd_q.push_back(c0 + 4000 + 4000 * k);
        end
        ENABLE = 1'b1;
        wait_cyc(c0 + 1);
        check("def_rise_at_E", int'(AZ_PULSE), 1);
        check("def_phase_high", int'(PHASE), 2);
        wait_cyc(c0 + 21);
        check("def_phase_low", int'(PHASE), 3);
        wait_cyc(c0 + 12000);
        check("def_pcnt3", int'(PULSE_CNT), 3);
        check("def_pd_last", int'(PERIOD_DONE), 1);
        ENABLE = 1'b0;
        wait_cyc(c0 + 12001);
        check("def_dis_phase", int'(PHASE), 0);
        check("def_dis_az", int'(AZ_PULSE), 0);
        do_reset();

        // Delay 5, high 3, low 4; mid-HIGH reconfig to high 6; disable in HIGH
        CONFIG = cfg(5'd5, 8'd3, 14'd4);
        c0 = cyc;
        push_pulse(c0 + 6, 3);
        push_pulse(c0 + 13, 3);
        push_pulse(c0 + 20, 3);
        push_pulse(c0 + 27, 3);
        push_pulse(c0 + 34, 6);
        push_pulse(c0 + 44, 2);
        pd_q.push_back(c0 + 12);
        pd_q.push_back(c0 + 19);
        pd_q.push_back(c0 + 26);
        pd_q.push_back(c0 + 33);
        pd_q.push_back(c0 + 43);
        ENABLE = 1'b1;
        wait_cyc(c0 + 1);
        check("dly_phase_first", int'(PHASE), 1);
        wait_cyc(c0 + 5);
        check("dly_phase_last", int'(PHASE), 1);
        check("dly_az_low", int'(AZ_PULSE), 0);
        wait_cyc(c0 + 6);
        check("dly_phase_high", int'(PHASE), 2);
        wait_cyc(c0 + 9);
        check("dly_phase_low", int'(PHASE), 3);
        wait_cyc(c0 + 13);
        check("dly_wrap_high", int'(PHASE), 2);
        wait_cyc(c0 + 20);
        check("dly_no_redelay", int'(PHASE), 2);
        wait_cyc(c0 + 28);
        CONFIG = cfg(5'd5, 8'd6, 14'd4);
        wait_cyc(c0 + 45);
        ENABLE = 1'b0;
        wait_cyc(c0 + 46);
        check("abort_phase", int'(PHASE), 0);
        check("abort_az", int'(AZ_PULSE), 0);
        check("abort_pcnt", int'(PULSE_CNT), 5);
        do_reset();

        // High 0 / low 5, then high 2 / low 0, then async reset mid-LOW
        CONFIG = cfg(5'd0, 8'd0, 14'd5);
        c0 = cyc;
        for (int k = 0; k < 4; k++) pd_q.push_back(c0 + 5 + 5 * k);
        for (int k = 0; k < 3; k++) begin
            push_pulse(c0 + 21 + 3 * k, 2);
            pd_q.push_back(c0 + 23 + 3 * k);
        end
        push_pulse(c0 + 30, 2);
        ENABLE = 1'b1;
        wait_cyc(c0 + 1);
        check("nh0_phase_low", int'(PHASE), 3);
        wait_cyc(c0 + 20);
        check("nh0_pcnt", int'(PULSE_CNT), 0);
        CONFIG = cfg(5'd0, 8'd2, 14'd0);
        wait_cyc(c0 + 22);
        check("nl0_phase_high", int'(PHASE), 2);
        wait_cyc(c0 + 29);
        check("nl0_pd", int'(PERIOD_DONE), 1);
        CONFIG = cfg(5'd0, 8'd2, 14'd20);
        wait_cyc(c0 + 35);
        check("midlow_pcnt", int'(PULSE_CNT), 4);
        check("midlow_phase", int'(PHASE), 3);
        #2;
        RESET = 1'b0;
        #1;
        check_reset_vals("async_rst");
        ENABLE = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        // SYNC in 10th LOW cycle with delay 2, then run to PULSE_CNT wrap
        CONFIG = cfg(5'd0, 8'd3, 14'd20);
        c0 = cyc;
        push_pulse(c0 + 1, 3);
        for (int j = 0; j < 259; j++) begin
            push_pulse(c0 + 16 + 5 * j, 4);
            pd_q.push_back(c0 + 20 + 5 * j);
        end
        ENABLE = 1'b1;
        wait_cyc(c0 + 13);
        SYNC   = 1'b1;
        CONFIG = cfg(5'd2, 8'd4, 14'd1);
        wait_cyc(c0 + 14);
        SYNC = 1'b0;
        check("sync_phase_d1", int'(PHASE), 1);
        check("sync_pcnt", int'(PULSE_CNT), 1);
        wait_cyc(c0 + 15);
        check("sync_phase_d2", int'(PHASE), 1);
        wait_cyc(c0 + 16);
        check("sync_phase_high", int'(PHASE), 2);
        check("sync_az", int'(AZ_PULSE), 1);
        wait_cyc(c0 + 1310);
        check("wrap_pcnt", int'(PULSE_CNT), 4);
        ENABLE = 1'b0;
        wait_cyc(c0 + 1311);
        check("wrap_dis_phase", int'(PHASE), 0);

        repeat (5) @(negedge CLK);
        check("pulse_q_drained", pulse_q.size(), 0);
        check("pd_q_drained", pd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
